// File: rtl/regf_arb_pkg.sv
// Shared encodings for the register-file arbiter: FSM states, rw polarity
// and the access wait-counter width.
package regf_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int CNT_W = 4;

    // Counter preload so that the last WAIT cycle is the one where read data is valid.
    function automatic logic [CNT_W-1:0] wait_load(input int access_cycles);
        return CNT_W'(access_cycles - 1);
    endfunction

endpackage

// File: rtl/regf_arbiter_rr.sv
// Two-way round-robin grant: combinational winner selection plus a register
// remembering the last requester served.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic upd_id,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_id;

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_id;
        end else begin
            gnt_id = req1 & ~req0;
        end
    end

    // Reset to "1 served last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id <= 1'b1;
        end else if (update) begin
            last_id <= upd_id;
        end
    end

endmodule

// File: rtl/regf_arbiter.sv
// Shares the single reg_file access port between the I2C slave (m0) and a
// local host (m1), one word per transaction, round-robin on contention.
module regf_arbiter
    import regf_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_rw,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_rw,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_ack,
    output logic                  regf_req,
    output logic                  regf_rw,
    output logic [ADDR_WIDTH-1:0] regf_addr,
    output logic [DATA_WIDTH-1:0] regf_write_data,
    input  logic [DATA_WIDTH-1:0] regf_read_data,
    output logic                  grant_id,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Requester handshake: mX_req is held high until the one-cycle mX_ack
    // pulse and dropped on the edge that ends it; a req still high in the
    // following IDLE cycle is a new request. Withdrawing req early does not
    // abort the access.

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_id;
    logic             rr_update;

    assign rr_update = (state == DONE);

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (m0_req),
        .req1      (m1_req),
        .update    (rr_update),
        .upd_id    (grant_id),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            grant_id        <= 1'b0;
            regf_rw         <= 1'b0;
            regf_addr       <= '0;
            regf_write_data <= '0;
            m0_rdata        <= '0;
            m1_rdata        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_id        <= arb_id;
                        regf_rw         <= arb_id ? m1_rw    : m0_rw;
                        regf_addr       <= arb_id ? m1_addr  : m0_addr;
                        regf_write_data <= arb_id ? m1_wdata : m0_wdata;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= wait_load(ACCESS_CYCLES);
                    state <= WAIT;
                end
                WAIT: begin
                    // Writes also run the full wait so all accesses share one latency.
                    if (cnt == '0) begin
                        if (regf_rw == RW_READ) begin
                            if (grant_id) begin
                                m1_rdata <= regf_read_data;
                            end else begin
                                m0_rdata <= regf_read_data;
                            end
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign regf_req  = (state == ISSUE);
    assign m0_ack    = (state == DONE) && !grant_id;
    assign m1_ack    = (state == DONE) && grant_id;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: doc/regf_arbiter.md
Name: regf_arbiter

Overview:
- Shares the single register-file access port (req / rw / addr / write data / read data) between two requesters.
- Requester 0 is the I2C slave controller. Requester 1 is a local host port, for example a debug or parallel-load path.
- Each request is a single-word access. Requests are arbitrated round-robin, and the block sequences the register-file handshake through a small FSM.
- Sits between the I2C slave controller / local host and reg_file inside tt_um_i2c_regf.

Parameters:
- DATA_WIDTH, 8, register word width.
- ADDR_WIDTH, 4, register address width.
- ACCESS_CYCLES, 1, register-file cycles from regf_req to valid regf_read_data. Legal values are 1 to 15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  requester 0 (I2C) access request; held high until m0_ack.
- m0_rw  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  register address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_rdata  out  DATA_WIDTH  read data; valid while m0_ack is high, held afterwards.
- m0_ack  out  1  one-cycle completion pulse.
- m1_req, m1_rw, m1_addr, m1_wdata, m1_rdata, m1_ack  same widths and directions, requester 1 (local host).
- regf_req  out  1  one-cycle access strobe to reg_file.
- regf_rw  out  1  1 = write, 0 = read.
- regf_addr  out  ADDR_WIDTH  access address.
- regf_write_data  out  DATA_WIDTH  write data.
- regf_read_data  in  DATA_WIDTH  read data from reg_file.
- grant_id  out  1  owner of the current or last transaction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs go to 0;
  - FSM goes to IDLE;
  - the round-robin pointer is set so that m0 wins the first tie;
  - the wait counter is cleared.
- Reset mid-transaction: the in-flight access is dropped, no ack is issued, and any reg_file strobe is cut immediately.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - sample m0_req and m1_req;
  - if neither is high, stay in IDLE;
  - if exactly one is high, grant it;
  - if both are high, grant the requester not granted last (round-robin);
  - on a grant, latch the winner's rw, addr and wdata, set grant_id, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - regf_req = 1, with regf_rw, regf_addr and regf_write_data driven from the latched values;
  - load the wait counter with ACCESS_CYCLES - 1;
  - go to WAIT.
- WAIT:
  - regf_req = 0; the regf_* address, rw and data outputs hold the latched values;
  - decrement the counter each cycle;
  - when the counter reaches 0, capture regf_read_data into the granted requester's rdata (reads only) and go to DONE.
  - Writes also pass through WAIT, so every transaction has the same latency.
- DONE (exactly 1 cycle):
  - pulse mX_ack for the granted requester;
  - update the round-robin pointer to the granted requester;
  - go to IDLE.
- Latency: request sampled at edge E; regf_req is high in cycle E+1; ack is high in cycle E+1+ACCESS_CYCLES+1. For ACCESS_CYCLES = 1 this is ack in cycle E+3.
- Throughput: one access per ACCESS_CYCLES + 3 cycles.
- Requester rules:
  - the requester must drop req on the edge that ends its ack cycle;
  - req still high in the following IDLE cycle is treated as a new request.
- Request withdrawn before ack: the access still completes and ack still pulses; the requester ignores the pulse.
- The losing requester simply waits; its inputs are not latched until it is granted.
- mX_rdata changes only on a completed read by that requester. Writes leave it unchanged.
- Both mX_ack outputs are never high in the same cycle.
- A request arriving in ISSUE, WAIT or DONE is considered at the next IDLE.
- Back-to-back: with both requesters continuously requesting, grants alternate m0, m1, m0, ...

Decomposition:
- Package regf_arb_pkg holds:
  - the state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  - RW_WRITE = 1'b1 and RW_READ = 1'b0;
  - wait-counter width localparam CNT_W = 4.
- One sub-module, rr_arbiter2:
  - combinational grant from the two reqs and the pointer;
  - pointer register updated on an update strobe from DONE.

Test Plan:
- Reset values: hold rst_n low, then release -> all outputs 0, busy = 0; pulse rst_n low during WAIT -> no ack, regf_req = 0, FSM in IDLE.
- Single write then read (ACCESS_CYCLES = 1):
  - m0 write addr 4'h3, data 8'hA5 -> regf_req high one cycle with rw = 1, addr 3, data A5; m0_ack high 3 cycles after the req is sampled.
  - m0 read addr 3, reg_file returning A5 -> m0_rdata = 8'hA5 during ack.
- Simultaneous requests after reset: m0 and m1 raised in the same cycle -> m0 granted first, m1 next; both kept asserted -> grant order m0, m1, m0, m1 with grant_id tracking.
- Withdrawn request: m1 read, m1_req dropped during WAIT -> m1_ack still pulses once; m1_rdata is updated.
- Latency parameter: ACCESS_CYCLES = 3, m1 read addr F, regf_read_data = 8'h5C valid 3 cycles after the strobe -> m1_ack 5 cycles after sampling, m1_rdata = 8'h5C.
- Req held past ack: m0_req kept high one cycle beyond its ack -> a second full transaction is performed for m0.
